sha_iterative_round_stage: RTL and testbench

Parametrised, handshaked SHA-256 compression stage that applies `ROUNDS` consecutive rounds, starting at round index `FIRST_ROUND`, to one `HashState` over `ROUNDS` clock cycles. It reuses a single round datapath iteratively and keeps the K constants for its rounds internally. Stages chain via valid/ready, so a full 64-round core is a cascade of these stages; the `newblock` sideband travels with each block. A stage trades throughput for area, unlike a fully unrolled single-round pipeline stage.

---
 rtl/sha_iterative_round_stage.sv | 194 +++++++++++++++++++
 tb/tb_sha_iterative_round_stage.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_iterative_round_stage.sv
// sha_iterative_round_stage
//
// Iterative SHA-256 compression stage. One round datapath is reused for
// ROUNDS consecutive rounds starting at round FIRST_ROUND, one round per
// clock. Stages chain through valid/ready, so a 64-round core is a cascade
// of these. The newblock flag travels with each block.
//
// Parameters
//   FIRST_ROUND  first SHA-256 round index applied (0..63)
//   ROUNDS       rounds applied per block (1..64), FIRST_ROUND+ROUNDS <= 64
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   state_i      working variables, a in [255:224] down to h in [31:0]
//   W_i          message words, W_i[32*j +: 32] feeds round FIRST_ROUND+j
//   newblock_i   sideband flag carried with the block
//   valid_i      input block present
//   ready_o      stage accepts an input block this cycle
//   state_o      working variables after ROUNDS rounds (valid with valid_o)
//   newblock_o   sideband flag of the block on state_o
//   valid_o      result present
//   ready_i      downstream accepts the result
//   blocks_o     completed-block count, saturating (only with the macro)
//
// Optional feature: define SHA_STAGE_PERF_CNT_EN to add the blocks_o
// completed-block counter.

module sha_iterative_round_stage #(
    parameter int FIRST_ROUND = 0,
    parameter int ROUNDS      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [255:0]          state_i,
    input  logic [32*ROUNDS-1:0]  W_i,
    input  logic                  newblock_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [255:0]          state_o,
    output logic                  newblock_o,
    output logic                  valid_o,
    input  logic                  ready_i
`ifdef SHA_STAGE_PERF_CNT_EN
    ,
    output logic [31:0]           blocks_o
`endif
);

    localparam int CNT_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    generate
        if (FIRST_ROUND < 0 || ROUNDS < 1 || FIRST_ROUND + ROUNDS > 64) begin : g_bad_cfg
            $error("sha_iterative_round_stage: FIRST_ROUND/ROUNDS out of range");
        end
    endgenerate

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    // One SHA-256 round on the packed working variables, all sums mod 2^32.
    function automatic logic [255:0] sha_round(input logic [255:0] s,
                                               input logic [31:0]  k,
                                               input logic [31:0]  w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + big_sigma1(e) + ((e & f) ^ (~e & g)) + k + w;
        t2 = big_sigma0(a) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] x);
        return (x == 32'hFFFFFFFF) ? x : x + 32'd1;
    endfunction

    logic [1:0]           fsm_p0;
    logic [CNT_W-1:0]     cnt_p0;
    logic [255:0]         st_p0;
    logic [32*ROUNDS-1:0] w_p0;
    logic                 nb_p0;

    logic                 accept;
    logic                 last_round;
    logic [5:0]           rnd_idx;
    logic [31:0]          w_cur;
    logic [255:0]         st_next;

    // Only DONE forwards ready_i combinationally; IDLE is always ready.
    assign ready_o    = (fsm_p0 == S_IDLE) || ((fsm_p0 == S_DONE) && ready_i);
    assign valid_o    = (fsm_p0 == S_DONE);
    assign accept     = valid_i && ready_o;
    assign last_round = (cnt_p0 == CNT_W'(ROUNDS - 1));
    assign rnd_idx    = 6'(FIRST_ROUND) + 6'(cnt_p0);
    assign w_cur      = w_p0[32*cnt_p0 +: 32];
    assign st_next    = sha_round(st_p0, K_TAB[rnd_idx], w_cur);

    assign state_o    = st_p0;
    assign newblock_o = nb_p0;

    // ---- stage boundary: held block state, round counter and FSM ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_p0 <= S_IDLE;
            cnt_p0 <= '0;
            st_p0  <= '0;
            nb_p0  <= 1'b0;
        end else begin
            case (fsm_p0)
                S_IDLE: begin
                    if (accept) begin
                        st_p0  <= state_i;
                        nb_p0  <= newblock_i;
                        cnt_p0 <= '0;
                        fsm_p0 <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    st_p0  <= st_next;
                    cnt_p0 <= cnt_p0 + CNT_W'(1);
                    if (last_round) begin
                        fsm_p0 <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (accept) begin
                        st_p0  <= state_i;
                        nb_p0  <= newblock_i;
                        cnt_p0 <= '0;
                        fsm_p0 <= S_BUSY;
                    end else if (ready_i) begin
                        fsm_p0 <= S_IDLE;
                    end
                end
                default: begin
                    fsm_p0 <= S_IDLE;
                end
            endcase
        end
    end

    // Message words are only read while BUSY, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            w_p0 <= W_i;
        end
    end

`ifdef SHA_STAGE_PERF_CNT_EN
    logic [31:0] blk_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt <= '0;
        end else if (valid_o && ready_i) begin
            blk_cnt <= sat_inc32(blk_cnt);
        end
    end

    assign blocks_o = blk_cnt;
`endif

endmodule

// File: tb/tb_sha_iterative_round_stage.sv
// Testbench for sha_iterative_round_stage.
// Instances: a 1-round stage (round 0), a 4x16-round cascade computing a
// full SHA-256 block, and a 4-round stage at rounds 60..63 used for
// back-to-back, backpressure, reset and (with SHA_STAGE_PERF_CNT_EN)
// counter saturation sequences. Expected results come from a behavioural
// SHA-256 model kept in this file.

module tb_sha_iterative_round_stage;

    logic clk = 1'b0;
    logic rst_n, rst4_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [255:0] DIGEST_ABC = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                           32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

    int unsigned K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // ---------------- behavioural model ----------------
    function automatic int unsigned ror(input int unsigned x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Applies rounds first..first+n-1; wv holds word r at [32*r +: 32].
    function automatic logic [255:0] ref_rounds(input logic [255:0] s, input logic [2047:0] wv,
                                                input int first, input int n);
        int unsigned v [8];
        int unsigned t1, t2, wr;
        logic [255:0] res;
        for (int i = 0; i < 8; i++) v[i] = s[255-32*i -: 32];
        for (int r = first; r < first + n; r++) begin
            wr = wv[32*r +: 32];
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[r] + wr;
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[0] = t1 + t2;
            v[4] = v[4] + t1;
        end
        for (int i = 0; i < 8; i++) res[255-32*i -: 32] = v[i];
        return res;
    endfunction

    function automatic logic [2047:0] msg_sched(input logic [511:0] blk);
        int unsigned w [64];
        logic [2047:0] out;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                   + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        for (int t = 0; t < 64; t++) out[32*t +: 32] = w[t];
        return out;
    endfunction

    function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        return r;
    endfunction

    function automatic logic [2047:0] at60(input logic [127:0] w);
        logic [2047:0] f;
        f = '0;
        f[32*60 +: 128] = w;
        return f;
    endfunction

    function automatic logic [255:0] rnd256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- DUT: 1 round at round 0 ----------------
    logic [255:0] r1_st, r1_so;
    logic [31:0]  r1_w;
    logic r1_nb, r1_vin, r1_ro, r1_nbo, r1_vo;
`ifdef SHA_STAGE_PERF_CNT_EN
    logic [31:0] r1_blk;
`endif

    sha_iterative_round_stage #(.FIRST_ROUND(0), .ROUNDS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .state_i(r1_st), .W_i(r1_w), .newblock_i(r1_nb),
        .valid_i(r1_vin), .ready_o(r1_ro), .state_o(r1_so), .newblock_o(r1_nbo),
        .valid_o(r1_vo), .ready_i(1'b1)
`ifdef SHA_STAGE_PERF_CNT_EN
        , .blocks_o(r1_blk)
`endif
    );

    // ---------------- DUT cascade: 4 x 16 rounds ----------------
    logic [255:0]  cs_in, cs1, cs2, cs3, cs4;
    logic [2047:0] cw;
    logic cv_in, cnb_in, cr0, cr1, cr2, cr3, c_rdy;
    logic cv1, cv2, cv3, cv4, cn1, cn2, cn3, cn4;
`ifdef SHA_STAGE_PERF_CNT_EN
    logic [31:0] cb1, cb2, cb3, cb4;
`endif

    sha_iterative_round_stage #(.FIRST_ROUND(0), .ROUNDS(16)) uc1 (
        .clk(clk), .rst_n(rst_n), .state_i(cs_in), .W_i(cw[0 +: 512]), .newblock_i(cnb_in),
        .valid_i(cv_in), .ready_o(cr0), .state_o(cs1), .newblock_o(cn1), .valid_o(cv1), .ready_i(cr1)
`ifdef SHA_STAGE_PERF_CNT_EN
        , .blocks_o(cb1)
`endif
    );
    sha_iterative_round_stage #(.FIRST_ROUND(16), .ROUNDS(16)) uc2 (
        .clk(clk), .rst_n(rst_n), .state_i(cs1), .W_i(cw[512 +: 512]), .newblock_i(cn1),
        .valid_i(cv1), .ready_o(cr1), .state_o(cs2), .newblock_o(cn2), .valid_o(cv2), .ready_i(cr2)
`ifdef SHA_STAGE_PERF_CNT_EN
        , .blocks_o(cb2)
`endif
    );
    sha_iterative_round_stage #(.FIRST_ROUND(32), .ROUNDS(16)) uc3 (
        .clk(clk), .rst_n(rst_n), .state_i(cs2), .W_i(cw[1024 +: 512]), .newblock_i(cn2),
        .valid_i(cv2), .ready_o(cr2), .state_o(cs3), .newblock_o(cn3), .valid_o(cv3), .ready_i(cr3)
`ifdef SHA_STAGE_PERF_CNT_EN
        , .blocks_o(cb3)
`endif
    );
    sha_iterative_round_stage #(.FIRST_ROUND(48), .ROUNDS(16)) uc4 (
        .clk(clk), .rst_n(rst_n), .state_i(cs3), .W_i(cw[1536 +: 512]), .newblock_i(cn3),
        .valid_i(cv3), .ready_o(cr3), .state_o(cs4), .newblock_o(cn4), .valid_o(cv4), .ready_i(c_rdy)
`ifdef SHA_STAGE_PERF_CNT_EN
        , .blocks_o(cb4)
`endif
    );

    // ---------------- DUT: 4 rounds at rounds 60..63 ----------------
    logic [255:0] q_st, q_so;
    logic [127:0] q_w;
    logic q_nb, q_vin, q_ro, q_nbo, q_vo, q_rdy;
`ifdef SHA_STAGE_PERF_CNT_EN
    logic [31:0] q_blk;
`endif

    sha_iterative_round_stage #(.FIRST_ROUND(60), .ROUNDS(4)) u4 (
        .clk(clk), .rst_n(rst4_n), .state_i(q_st), .W_i(q_w), .newblock_i(q_nb),
        .valid_i(q_vin), .ready_o(q_ro), .state_o(q_so), .newblock_o(q_nbo),
        .valid_o(q_vo), .ready_i(q_rdy)
`ifdef SHA_STAGE_PERF_CNT_EN
        , .blocks_o(q_blk)
`endif
    );

    // One block through u4 with ready_i held high; checks result and flag.
    task automatic q_block(input logic [255:0] s, input logic [127:0] w, input logic nb, input string nm);
        logic [255:0] e;
        int k;
        e = ref_rounds(s, at60(w), 60, 4);
        @(negedge clk);
        q_st = s; q_w = w; q_nb = nb; q_vin = 1'b1; q_rdy = 1'b1;
        k = 0;
        while (!q_ro && k < 20) begin @(negedge clk); k++; end
        @(posedge clk); #1;
        q_vin = 1'b0;
        k = 0;
        while (!q_vo && k < 20) begin @(posedge clk); #1; k++; end
        chk({nm, " valid"}, 256'(q_vo), 256'(1));
        chk({nm, " state"}, q_so, e);
        chk({nm, " newblock"}, 256'(q_nbo), 256'(nb));
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [255:0] st;
        logic [31:0]  w;
        logic         nb;
        logic [255:0] exp;
    } vec_t;

    typedef struct {
        logic [255:0] e;
        logic         nb;
        int           c;
    } exp_t;

    vec_t tbl [6];
    exp_t qq [$];

    initial begin
        int k, sent, got;
        bit need;
        exp_t x;
        logic [255:0] ea, eb, sa, sb;
        logic [127:0] wa, wb;

        rst_n = 1'b0; rst4_n = 1'b0;
        r1_st = '0; r1_w = '0; r1_nb = 1'b0; r1_vin = 1'b0;
        cs_in = '0; cw = '0; cv_in = 1'b0; cnb_in = 1'b0; c_rdy = 1'b1;
        q_st = '0; q_w = '0; q_nb = 1'b0; q_vin = 1'b0; q_rdy = 1'b1;

        // ---- reset state ----
        #2;
        chk("rst u1 valid_o", 256'(r1_vo), 256'(0));
        chk("rst u1 ready_o", 256'(r1_ro), 256'(1));
        chk("rst u1 state_o", r1_so, 256'(0));
        chk("rst u1 newblock_o", 256'(r1_nbo), 256'(0));
        chk("rst u4 ready_o", 256'(q_ro), 256'(1));
        chk("rst u4 valid_o", 256'(q_vo), 256'(0));
        chk("rst cascade ready_o", 256'(cr0), 256'(1));
`ifdef SHA_STAGE_PERF_CNT_EN
        chk("rst blocks_o", 256'(q_blk), 256'(0));
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1; rst4_n = 1'b1;

        // ---- table-driven single rounds ----
        tbl[0] = '{IV, 32'h61626380, 1'b1,
                   {32'h5d6aebcd, 32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372,
                    32'hfa2a4622, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab}};
        tbl[1] = '{256'h0, 32'h0, 1'b0, {32'h428a2f98, 96'h0, 32'h428a2f98, 96'h0}};
        tbl[2] = '{{8{32'hffffffff}}, 32'h0, 1'b1,
                   {32'h428a2f93, {3{32'hffffffff}}, 32'h428a2f94, {3{32'hffffffff}}}};
        for (int i = 3; i < 6; i++) begin
            tbl[i].st  = rnd256();
            tbl[i].w   = $urandom();
            tbl[i].nb  = 1'($urandom_range(0, 1));
            tbl[i].exp = ref_rounds(tbl[i].st, {2016'h0, tbl[i].w}, 0, 1);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            r1_st = tbl[i].st; r1_w = tbl[i].w; r1_nb = tbl[i].nb; r1_vin = 1'b1;
            k = 0;
            while (!r1_ro && k < 10) begin @(negedge clk); k++; end
            @(posedge clk); #1;
            chk($sformatf("vec%0d busy valid_o", i), 256'(r1_vo), 256'(0));
            @(negedge clk);
            r1_vin = 1'b0;
            @(posedge clk); #1;
            chk($sformatf("vec%0d valid_o", i), 256'(r1_vo), 256'(1));
            chk($sformatf("vec%0d state_o", i), r1_so, tbl[i].exp);
            chk($sformatf("vec%0d newblock_o", i), 256'(r1_nbo), 256'(tbl[i].nb));
        end

        // ---- chained "abc" message through the cascade ----
        cw = msg_sched({32'h61626380, 448'h0, 32'h00000018});
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            cs_in = IV; cnb_in = (b == 0); cv_in = 1'b1;
            k = 0;
            while (!cr0 && k < 200) begin @(negedge clk); k++; end
            @(posedge clk); #1;
            cv_in = 1'b0;
            k = 0;
            while (!cv4 && k < 300) begin @(posedge clk); #1; k++; end
            chk($sformatf("abc%0d valid", b), 256'(cv4), 256'(1));
            chk($sformatf("abc%0d digest", b), add_words(cs4, IV), DIGEST_ABC);
            chk($sformatf("abc%0d newblock", b), 256'(cn4), 256'(b == 0));
        end

        // ---- back-to-back, random blocks ----
        sent = 0; got = 0; need = 1'b1; k = 0; q_rdy = 1'b1;
        while (got < 10 && k < 200) begin
            @(negedge clk);
            if (need && sent < 10) begin
                q_st = rnd256();
                q_w = {$urandom(), $urandom(), $urandom(), $urandom()};
                q_nb = 1'($urandom_range(0, 1));
                q_vin = 1'b1;
                need = 1'b0;
            end
            if (sent >= 10) q_vin = 1'b0;
            if (q_vin && q_ro) begin
                x.e = ref_rounds(q_st, at60(q_w), 60, 4);
                x.nb = q_nb;
                x.c = cyc + 1;
                qq.push_back(x);
                sent++;
                need = 1'b1;
            end
            @(posedge clk); #1;
            k++;
            if (q_vo && q_rdy) begin
                if (qq.size() == 0) begin
                    chk($sformatf("b2b%0d unexpected result", got), 256'(1), 256'(0));
                end else begin
                    x = qq.pop_front();
                    chk($sformatf("b2b%0d state", got), q_so, x.e);
                    chk($sformatf("b2b%0d newblock", got), 256'(q_nbo), 256'(x.nb));
                    chk($sformatf("b2b%0d latency", got), 256'(cyc - x.c), 256'(4));
                end
                got++;
            end
        end
        chk("b2b blocks completed", 256'(got), 256'(10));
        @(posedge clk); #1;

        // ---- backpressure ----
        sa = rnd256(); wa = {$urandom(), $urandom(), $urandom(), $urandom()};
        sb = rnd256(); wb = {$urandom(), $urandom(), $urandom(), $urandom()};
        ea = ref_rounds(sa, at60(wa), 60, 4);
        eb = ref_rounds(sb, at60(wb), 60, 4);
        @(negedge clk);
        q_st = sa; q_w = wa; q_nb = 1'b1; q_vin = 1'b1; q_rdy = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        q_st = sb; q_w = wb; q_nb = 1'b0; q_vin = 1'b1;
        k = 0;
        while (!q_vo && k < 20) begin @(posedge clk); #1; k++; end
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp hold%0d valid", i), 256'(q_vo), 256'(1));
            chk($sformatf("bp hold%0d state", i), q_so, ea);
            chk($sformatf("bp hold%0d newblock", i), 256'(q_nbo), 256'(1));
            chk($sformatf("bp hold%0d ready_o", i), 256'(q_ro), 256'(0));
            @(posedge clk); #1;
        end
        @(negedge clk);
        q_rdy = 1'b1;
        #1;
        chk("bp ready_o follows ready_i", 256'(q_ro), 256'(1));
        @(posedge clk); #1;
        q_vin = 1'b0;
        chk("bp next block accepted", 256'(q_vo), 256'(0));
        k = 0;
        while (!q_vo && k < 20) begin @(posedge clk); #1; k++; end
        chk("bp block B state", q_so, eb);
        chk("bp block B newblock", 256'(q_nbo), 256'(0));
        @(posedge clk); #1;

        // ---- asynchronous reset two cycles into BUSY ----
        @(negedge clk);
        q_st = rnd256(); q_w = {$urandom(), $urandom(), $urandom(), $urandom()};
        q_nb = 1'b1; q_vin = 1'b1; q_rdy = 1'b1;
        @(posedge clk); #1;
        q_vin = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst4_n = 1'b0;
        #1;
        chk("midrst valid_o", 256'(q_vo), 256'(0));
        chk("midrst ready_o", 256'(q_ro), 256'(1));
        chk("midrst state_o", q_so, 256'(0));
        chk("midrst newblock_o", 256'(q_nbo), 256'(0));
`ifdef SHA_STAGE_PERF_CNT_EN
        chk("midrst blocks_o", 256'(q_blk), 256'(0));
`endif
        @(negedge clk);
        rst4_n = 1'b1;
        q_block(rnd256(), {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, "post-reset");

`ifdef SHA_STAGE_PERF_CNT_EN
        // ---- completed-block counter saturation ----
        chk("blocks_o after one block", 256'(q_blk), 256'(1));
        @(negedge clk);
        force u4.blk_cnt = 32'hFFFFFFFE;
        #1;
        release u4.blk_cnt;
        for (int i = 0; i < 3; i++) begin
            q_block(rnd256(), {$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1,
                    $sformatf("sat%0d", i));
            chk($sformatf("sat%0d blocks_o", i), 256'(q_blk), 256'(32'hFFFFFFFF));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
